// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes and flag bit positions.
// Used by the execute stage and the decoder.
package cpu_pkg;

    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned COND_W  = 4;

    // Bit positions inside the {N,Z,C,V} flags vector
    localparam int unsigned F_N = 3;
    localparam int unsigned F_Z = 2;
    localparam int unsigned F_C = 1;
    localparam int unsigned F_V = 0;

    typedef enum logic [COND_W-1:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_e;

endpackage

// File: rtl/etapa_ex_banderas_if.sv
// Execute-stage bus: upstream ALU handshake, downstream writeback handshake and stage status.
interface etapa_ex_banderas_if #(
    parameter int unsigned n  = 4,
    parameter int unsigned RW = 4,
    parameter int unsigned CW = 8
);
    import cpu_pkg::*;

    logic                 valid_in;
    logic                 ready_in;
    logic [n-1:0]         resultado;
    logic [FLAGS_W-1:0]   banderas;
    logic [RW-1:0]        rd;
    logic                 we;
    logic                 set_flags;
    logic [COND_W-1:0]    cond;
    logic                 flush;
    logic                 valid_out;
    logic                 ready_out;
    logic [n-1:0]         resultado_q;
    logic [RW-1:0]        rd_q;
    logic                 we_q;
    logic [FLAGS_W-1:0]   banderas_q;
    logic [CW-1:0]        anuladas;

    // Stage side
    modport slave (
        input  valid_in, resultado, banderas, rd, we, set_flags, cond, flush, ready_out,
        output ready_in, valid_out, resultado_q, rd_q, we_q, banderas_q, anuladas
    );

    // Upstream/downstream side
    modport master (
        output valid_in, resultado, banderas, rd, we, set_flags, cond, flush, ready_out,
        input  ready_in, valid_out, resultado_q, rd_q, we_q, banderas_q, anuladas
    );

endinterface

// File: rtl/etapa_ex_banderas_eval_condicion.sv
// Combinational condition-code evaluation against the architectural flags.
module eval_condicion
    import cpu_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] banderas_q,
    output logic               pass_c
);

    logic n_f, z_f, c_f, v_f;

    assign n_f = banderas_q[F_N];
    assign z_f = banderas_q[F_Z];
    assign c_f = banderas_q[F_C];
    assign v_f = banderas_q[F_V];

    always_comb begin
        pass_c = 1'b0;
        case (cond_e'(cond))
            EQ: pass_c = z_f;
            NE: pass_c = !z_f;
            CS: pass_c = c_f;
            CC: pass_c = !c_f;
            MI: pass_c = n_f;
            PL: pass_c = !n_f;
            VS: pass_c = v_f;
            VC: pass_c = !v_f;
            HI: pass_c = c_f && !z_f;
            LS: pass_c = !c_f || z_f;
            GE: pass_c = (n_f == v_f);
            LT: pass_c = (n_f != v_f);
            GT: pass_c = !z_f && (n_f == v_f);
            LE: pass_c = z_f || (n_f != v_f);
            AL: pass_c = 1'b1;
            NV: pass_c = 1'b0;
            default: pass_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/etapa_ex_banderas.sv
// Execute-to-writeback stage: captures ALU result/flags, holds the flags register,
// predicates each instruction on its condition code and counts annulled instructions.
module etapa_ex_banderas
    import cpu_pkg::*;
#(
    parameter int unsigned n  = 4,
    parameter int unsigned RW = 4,
    parameter int unsigned CW = 8
) (
    input logic                clk,
    input logic                rst,
    etapa_ex_banderas_if.slave bus
);

    logic                 valid_q,     valid_d;
    logic [n-1:0]         resultado_q, resultado_d;
    logic [RW-1:0]        rd_q,        rd_d;
    logic                 we_q,        we_d;
    logic [FLAGS_W-1:0]   banderas_q,  banderas_d;
    logic [CW-1:0]        anuladas_q,  anuladas_d;

    logic ready_in_c;
    logic fire_in_c;
    logic fire_out_c;
    logic pass_c;

    eval_condicion u_eval_condicion (
        .cond       (bus.cond),
        .banderas_q (banderas_q),
        .pass_c     (pass_c)
    );

    assign ready_in_c = !valid_q || bus.ready_out;
    assign fire_in_c  = bus.valid_in && ready_in_c;
    assign fire_out_c = valid_q && bus.ready_out;

    // Next-state: flush discards both the held and the incoming instruction
    always_comb begin
        valid_d     = valid_q;
        resultado_d = resultado_q;
        rd_d        = rd_q;
        we_d        = we_q;
        banderas_d  = banderas_q;
        anuladas_d  = anuladas_q;

        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (fire_in_c) begin
            valid_d     = 1'b1;
            resultado_d = bus.resultado;
            rd_d        = bus.rd;
            we_d        = bus.we && pass_c;
            if (bus.set_flags && pass_c) begin
                banderas_d = bus.banderas;
            end
            if (!pass_c && (anuladas_q != {CW{1'b1}})) begin
                anuladas_d = anuladas_q + CW'(1);
            end
        end else if (fire_out_c) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            resultado_q <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            banderas_q  <= '0;
            anuladas_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            resultado_q <= resultado_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            banderas_q  <= banderas_d;
            anuladas_q  <= anuladas_d;
        end
    end

    assign bus.ready_in    = ready_in_c;
    assign bus.valid_out   = valid_q;
    assign bus.resultado_q = resultado_q;
    assign bus.rd_q        = rd_q;
    assign bus.we_q        = we_q;
    assign bus.banderas_q  = banderas_q;
    assign bus.anuladas    = anuladas_q;

endmodule

// File: tb/tb_etapa_ex_banderas.sv
// Self-checking bench for etapa_ex_banderas: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_etapa_ex_banderas;

    localparam int unsigned N_W  = 4;
    localparam int unsigned R_W  = 4;
    localparam int unsigned C_W  = 2;
    localparam int          CMAX = (1 << C_W) - 1;

    logic clk;
    logic rst;

    etapa_ex_banderas_if #(.n(N_W), .RW(R_W), .CW(C_W)) bus ();

    etapa_ex_banderas #(.n(N_W), .RW(R_W), .CW(C_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_valid, m_res, m_rd, m_we, m_flags, m_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Condition predicate: pairs of codes share a base test, odd code negates it
    function automatic int cond_ok(input int c, input int f);
        int nf, zf, cf, vf, b;
        nf = (f >> 3) & 1; zf = (f >> 2) & 1; cf = (f >> 1) & 1; vf = f & 1;
        case (c / 2)
            0: b = zf;
            1: b = cf;
            2: b = nf;
            3: b = vf;
            4: b = (cf == 1 && zf == 0) ? 1 : 0;
            5: b = (nf == vf) ? 1 : 0;
            6: b = (zf == 0 && nf == vf) ? 1 : 0;
            default: b = 1;
        endcase
        return (c % 2 == 1) ? 1 - b : b;
    endfunction

    task automatic set_idle();
        bus.valid_in  = 1'b0;
        bus.resultado = '0;
        bus.banderas  = '0;
        bus.rd        = '0;
        bus.we        = 1'b0;
        bus.set_flags = 1'b0;
        bus.cond      = 4'd14;
        bus.flush     = 1'b0;
        bus.ready_out = 1'b1;
    endtask

    task automatic drive(input int res, input int fl, input int rdi, input int wei,
                         input int sf, input int c);
        bus.valid_in  = 1'b1;
        bus.resultado = N_W'(res);
        bus.banderas  = 4'(fl);
        bus.rd        = R_W'(rdi);
        bus.we        = 1'(wei);
        bus.set_flags = 1'(sf);
        bus.cond      = 4'(c);
    endtask

    // One clock: check ready_in, advance model, clock, compare registered outputs
    task automatic cycle();
        int rdy, fin, fout, p;
        #1;
        rdy = (m_valid == 0 || bus.ready_out == 1'b1) ? 1 : 0;
        chk("ready_in", int'(bus.ready_in), rdy);
        fin  = (bus.valid_in == 1'b1 && rdy == 1) ? 1 : 0;
        fout = (m_valid == 1 && bus.ready_out == 1'b1) ? 1 : 0;
        p    = cond_ok(int'(bus.cond), m_flags);
        if (rst) begin
            m_valid = 0; m_res = 0; m_rd = 0; m_we = 0; m_flags = 0; m_cnt = 0;
        end else if (bus.flush) begin
            m_valid = 0;
        end else if (fin == 1) begin
            m_valid = 1;
            m_res   = int'(bus.resultado);
            m_rd    = int'(bus.rd);
            m_we    = (bus.we == 1'b1 && p == 1) ? 1 : 0;
            if (bus.set_flags == 1'b1 && p == 1) m_flags = int'(bus.banderas);
            if (p == 0 && m_cnt < CMAX) m_cnt++;
        end else if (fout == 1) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("valid_out",  int'(bus.valid_out),  m_valid);
        chk("banderas_q", int'(bus.banderas_q), m_flags);
        chk("anuladas",   int'(bus.anuladas),   m_cnt);
        if (m_valid == 1) begin
            chk("resultado_q", int'(bus.resultado_q), m_res);
            chk("rd_q",        int'(bus.rd_q),        m_rd);
            chk("we_q",        int'(bus.we_q),        m_we);
        end
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        m_valid = 0; m_res = 0; m_rd = 0; m_we = 0; m_flags = 0; m_cnt = 0;
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;

        // Reset
        do_reset();
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_flags", int'(bus.banderas_q), 0);
        chk("rst_cnt",   int'(bus.anuladas), 0);
        chk("rst_ready", int'(bus.ready_in), 1);

        // Flag dependency between back-to-back instructions
        drive(0, 4'b0100, 0, 0, 1, 14);
        cycle();
        chk("dep_flags", int'(bus.banderas_q), 4'b0100);
        drive(5, 4'b0000, 3, 1, 0, 0);
        cycle();
        chk("dep_we", int'(bus.we_q), 1);
        chk("dep_rd", int'(bus.rd_q), 3);
        set_idle();
        cycle();

        // Condition fail annuls write and flag update
        do_reset();
        drive(7, 4'b1000, 2, 1, 1, 0);
        cycle();
        chk("fail_we",    int'(bus.we_q), 0);
        chk("fail_valid", int'(bus.valid_out), 1);
        chk("fail_flags", int'(bus.banderas_q), 0);
        chk("fail_cnt",   int'(bus.anuladas), 1);

        // Backpressure: held instruction stays put for 3 cycles
        drive(9, 4'b0001, 6, 1, 0, 14);
        bus.ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_res", int'(bus.resultado_q), 7);
            chk("bp_rdy", int'(bus.ready_in), 0);
        end
        bus.ready_out = 1'b1;
        cycle();
        chk("bp_load", int'(bus.resultado_q), 9);
        set_idle();
        cycle();

        // Flush beats a same-cycle accept
        drive(3, 4'b0010, 1, 1, 1, 14);
        bus.flush = 1'b1;
        cycle();
        chk("fl_valid", int'(bus.valid_out), 0);
        chk("fl_flags", int'(bus.banderas_q), 0);
        chk("fl_cnt",   int'(bus.anuladas), 1);
        set_idle();

        // Counter saturation with CW=2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(i, 4'b1111, i, 1, 1, 15);
            cycle();
            chk("sat_cnt", int'(bus.anuladas), (i < 3) ? i + 1 : 3);
        end
        set_idle();
        cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.valid_in  = 1'($urandom_range(0, 3) != 0);
            bus.resultado = N_W'($urandom);
            bus.banderas  = 4'($urandom);
            bus.rd        = R_W'($urandom);
            bus.we        = 1'($urandom);
            bus.set_flags = 1'($urandom_range(0, 2) != 0);
            bus.cond      = 4'($urandom);
            bus.flush     = 1'($urandom_range(0, 11) == 0);
            bus.ready_out = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;
        set_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/etapa_ex_banderas.md
Name: etapa_ex_banderas

Overview:
- Execute-to-writeback stage that sits directly downstream of the adder/ALU.
- Captures the ALU result and its 4-bit flags vector. Flag order is [3]=N, [2]=Z, [1]=C, [0]=V.
- Holds the architectural flags register and evaluates each instruction's 4-bit condition code against it.
- Forwards the result to writeback over a valid/ready handshake, annulling register writes for instructions whose condition fails.

Parameters:
- n, 4, datapath width; must match the ALU width.
- RW, 4, destination register index width.
- CW, 8, width of the annulled-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream has an instruction.
- ready_in  out  1  stage can accept this cycle.
- resultado  in  n  ALU result.
- banderas  in  4  ALU flags {N,Z,C,V}.
- rd  in  RW  destination register.
- we  in  1  instruction writes rd.
- set_flags  in  1  instruction updates the flags register.
- cond  in  4  condition code.
- flush  in  1  kill the held instruction and any instruction accepted this cycle.
- valid_out  out  1  stage holds an instruction.
- ready_out  in  1  downstream accepts.
- resultado_q  out  n  registered result.
- rd_q  out  RW  registered destination.
- we_q  out  1  registered write enable, forced 0 if the condition failed.
- banderas_q  out  4  architectural flags register.
- anuladas  out  CW  count of condition-failed instructions.

Behaviour:
- Reset (rst=1 at edge): valid_out=0, resultado_q=0, rd_q=0, we_q=0, banderas_q=4'b0000, anuladas=0. Reset overrides flush and any handshake, including mid-transfer.
- ready_in = !valid_out || ready_out. This is combinational, with no dependence on valid_in.
- fire_in = valid_in && ready_in. fire_out = valid_out && ready_out.
- Condition pass uses banderas_q as it is before the edge:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&&!Z. 9 LS: !C||Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z&&(N==V). 13 LE: Z||(N!=V).
  - 14 AL: 1. 15 NV: 0.
- On fire_in with flush=0:
  - Load resultado_q, rd_q and valid_out=1.
  - we_q = we && pass.
  - If set_flags && pass: banderas_q <= banderas at the same edge. The next accepted instruction therefore sees the updated flags, and no hazard logic is needed.
  - If !pass: anuladas increments, saturating at 2^CW-1.
- Latency: one cycle from fire_in to valid_out.
- Throughput: one instruction per cycle while ready_out=1.
- On fire_out without fire_in: valid_out <= 0. Data registers hold their values; we_q may be left as is.
- Output stability: when valid_out=1 and ready_out=0, all outputs stay stable and ready_in=0.
- flush=1:
  - valid_out <= 0.
  - An instruction firing the same cycle is discarded: no flag update and no counter increment.
  - Flags updated by earlier instructions are kept.
  - ready_in is unaffected by flush.
- The flags update occurs only on accepted, unflushed, passing, set_flags instructions. banderas_q is never written otherwise.
- Output widths are exact. There is no arithmetic beyond the saturating counter.

Decomposition:
- Shared package cpu_pkg:
  - enum cond_e (EQ..NV, 4 bits).
  - Flag index constants F_N=3, F_Z=2, F_C=1, F_V=0.
  - Package contents are used by both this stage and the decoder.
- One sub-module: eval_condicion, combinational, taking (cond, banderas_q) and producing pass.
- Everything else stays in etapa_ex_banderas.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release -> valid_out=0, banderas_q=0000, anuladas=0, ready_in=1.
- Flag dependency: cycle 0 accept resultado=0, banderas=0100, set_flags=1, cond=AL; cycle 1 accept cond=EQ, we=1, rd=3, ready_out=1 throughout -> banderas_q=0100 after cycle 0; second instruction emerges with we_q=1, rd_q=3.
- Condition fail: banderas_q=0000, accept cond=EQ, we=1, set_flags=1, banderas=1000 -> we_q=0, valid_out=1, banderas_q stays 0000, anuladas=1.
- Backpressure: valid_out=1, ready_out=0 for 3 cycles, valid_in=1 -> ready_in=0, outputs stable; ready_out=1 -> next instruction loads the following cycle.
- Flush priority: flush=1 in the same cycle as fire_in with set_flags=1, cond=AL, banderas=0010 -> valid_out=0, banderas_q unchanged, anuladas unchanged.
- Counter saturation with CW=2: 5 consecutive cond=NV instructions -> anuladas reads 1, 2, 3, 3, 3.
